rv32i_multicycle_sequencer: RTL
===============================

Name: rv32i_multicycle_sequencer

Overview:
- Parametrised control sequencer for the multi-cycle RV32I core.
- Owns the PC, the instruction register and the retire counter.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and talks to instruction and data memory through a req/ready handshake, so memory latency can vary.
- Sits between memory, decoder, ALU and register file. It replaces the ad-hoc state logic in the top level.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INSTRET_WIDTH, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, wait-cycle limit for a memory handshake; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ready  in  1  data access complete this cycle.
- alu_result  in  32  ALU output: result, effective address, or jump/branch target.
- branch_taken  in  1  branch condition from the ALU comparator.
- instr  out  32  instruction register; feeds the decoder.
- pc  out  32  current program counter.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_wsel  out  2  writeback source: 00 ALU, 01 dmem data, 10 pc+4.
- state  out  3  current FSM state, for debug.
- instret  out  INSTRET_WIDTH  count of retired instructions.
- trap  out  1  sticky fault flag.

Behaviour:
- Reset (async, reset_n low):
  - pc=RESET_VECTOR, instr=0, state=FETCH, instret=0, trap=0.
  - All req/we/rf_we outputs are 0 combinationally while reset is held.
  - Reset during an outstanding request abandons it; memory must tolerate an abandoned request.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7.
- Handshake rules:
  - req stays high and its address/we stay stable until the cycle in which ready=1. The transfer completes in that cycle.
  - ready is ignored while req=0.
  - A same-cycle ready (zero wait) is legal.
- FETCH:
  - imem_req=1. On imem_ready, instr<=imem_rdata and the FSM goes to DECODE.
- DECODE (1 cycle), opcode classes:
  - Legal: LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011.
  - FENCE 0001111 and SYSTEM 1110011 execute as NOPs.
  - Any other opcode goes to TRAP.
- EXECUTE (1 cycle):
  - LOAD or STORE: go to MEMORY.
  - BRANCH taken: check the target. If alu_result[1:0]!=0, go to TRAP. Otherwise pc<=alu_result, instret++, go to FETCH.
  - BRANCH not taken: pc<=pc+4, instret++, go to FETCH.
  - JAL/JALR: compute the target as alu_result with bit0 cleared. If target[1]=1, go to TRAP; else go to WRITEBACK.
  - FENCE/SYSTEM: pc+4, instret++, go to FETCH.
  - All others: go to WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_we=1 for STORE; address comes from alu_result outside this block.
  - On dmem_ready, LOAD goes to WRITEBACK.
  - On dmem_ready, STORE does pc+4, instret++, go to FETCH.
- WRITEBACK (1 cycle):
  - rf_we=1 for exactly one cycle.
  - rf_wsel: LOAD=01, JAL/JALR=10, all others=00.
  - pc: JAL/JALR take the masked target; all others take pc+4.
  - instret++, then go to FETCH.
  - rd=x0 still pulses rf_we; the register file discards the write.
- PC arithmetic: 32-bit, wraps modulo 2^32. instret wraps to 0 on overflow.
- TRAP:
  - Sticky; only reset exits.
  - trap=1, all requests 0, rf_we=0.
  - pc and instr hold the faulting instruction's values; instret is not incremented.
- Pulse rule: rf_we and retire happen at most once per instruction.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on entry to FETCH or MEMORY and increments each cycle that req=1 and ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to TRAP.
  - A ready arriving in that same cycle wins: the transfer completes and there is no trap.
- Disabled: no counter logic exists, and the FSM waits indefinitely for ready.

Test Plan:
- Reset: assert reset_n=0 while in FETCH with imem_req=1 -> imem_req drops immediately; after release pc=RESET_VECTOR, state=0, instret=0, trap=0.
- ADDI (0x00500093) with imem_ready delayed 3 cycles -> imem_req held 4 cycles at addr 0; rf_we pulses once with rf_wsel=00; pc=4; instret=1.
- LW with dmem_ready after 2 wait cycles -> dmem_req held 3 cycles with dmem_we=0; rf_wsel=01; pc+4; a following SW has dmem_we=1, no rf_we, pc+4.
- BEQ at pc=0x10:
  - taken, alu_result=0x40 -> pc=0x40, no rf_we.
  - not taken -> pc=0x14.
  - taken, alu_result=0x42 -> trap=1, pc stays 0x10.
- JALR with alu_result=0x101 -> pc=0x100, rf_wsel=10, rf_we single pulse, instret+1.
- Illegal word 0x00000000 -> TRAP, trap sticky over 10 cycles, no requests; reset recovers.
- With SEQ_TIMEOUT_EN and imem_ready never asserted -> trap after 16 wait cycles.

Source files
------------

// File: rtl/rv32i_multicycle_sequencer_if.sv
// Memory-side handshake bundle for the multi-cycle RV32I sequencer.
// master: sequencer side (drives requests). slave: memory side (drives ready/data).
//   imem_req/imem_addr  fetch request and address
//   imem_ready/imem_rdata  fetch completion and instruction word
//   dmem_req/dmem_we    data access request, 1 = store
//   dmem_ready          data access completion
interface rv32i_multicycle_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/rv32i_multicycle_sequencer.sv
// Control sequencer for the multi-cycle RV32I core. Owns pc, the instruction
// register and the retire counter, and steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with req/ready memory handshakes.
// Ports:
//   clk, reset_n      clock (rising edge), async active-low reset
//   bus               memory handshake interface (master modport)
//   alu_result        ALU result / effective address / jump-branch target
//   branch_taken      branch comparator outcome
//   instr, pc         instruction register and program counter
//   rf_we, rf_wsel    register-file write strobe and source (00 ALU, 01 mem, 10 pc+4)
//   state             FSM state for debug (FETCH=0 .. WRITEBACK=4, TRAP=7)
//   instret           retired-instruction count
//   trap              sticky fault flag
// Optional: define SEQ_TIMEOUT_EN to trap when a handshake waits TIMEOUT_CYCLES.
module rv32i_multicycle_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          INSTRET_WIDTH  = 32,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  rv32i_multicycle_sequencer_if.master bus,
  input  logic [31:0]                  alu_result,
  input  logic                         branch_taken,
  output logic [31:0]                  instr,
  output logic [31:0]                  pc,
  output logic                         rf_we,
  output logic [1:0]                   rf_wsel,
  output logic [2:0]                   state,
  output logic [INSTRET_WIDTH-1:0]     instret,
  output logic                         trap
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEMORY  = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state_q, state_n;
  logic [31:0] pc_n, pc_plus4, tgt, tgt_q;
  logic        pc_ld, instr_ld, tgt_ld, retire;
  logic        is_load, is_store, is_branch, is_jump, is_nop, is_legal;
  logic        expired;

  // Instruction class is decoded from the held instruction register, so it
  // stays valid for every state after FETCH.
  wire [6:0] opc = instr[6:0];
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jump   = (opc == OP_JAL) || (opc == OP_JALR);
  assign is_nop    = (opc == OP_FENCE) || (opc == OP_SYSTEM);
  assign is_legal  = is_load || is_store || is_branch || is_jump || is_nop ||
                     (opc == OP_IMM) || (opc == OP_OP) ||
                     (opc == OP_LUI) || (opc == OP_AUIPC);

  assign pc_plus4       = pc + 32'd4;
  assign tgt            = {alu_result[31:1], 1'b0};
  assign bus.imem_addr  = pc;
  assign state          = state_q;
  assign trap           = (state_q == S_TRAP);
  assign rf_wsel        = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);

`ifdef SEQ_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCNT_W-1:0] wcnt;
  logic              waiting;

  // Counter is zero whenever no handshake is stalled, which covers the
  // clear-on-entry to FETCH and MEMORY.
  assign waiting = (bus.imem_req & ~bus.imem_ready) | (bus.dmem_req & ~bus.dmem_ready);
  assign expired = (wcnt == WCNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wcnt <= '0;
    else if (waiting) wcnt <= wcnt + WCNT_W'(1);
    else              wcnt <= '0;
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc      <= RESET_VECTOR;
      instr   <= '0;
      instret <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_n;
      if (instr_ld) instr   <= bus.imem_rdata;
      if (pc_ld)    pc      <= pc_n;
      if (retire)   instret <= instret + INSTRET_WIDTH'(1);
      if (tgt_ld)   tgt_q   <= tgt;
    end
  end

  always_comb begin
    state_n      = state_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    rf_we        = 1'b0;
    pc_ld        = 1'b0;
    pc_n         = pc_plus4;
    instr_ld     = 1'b0;
    tgt_ld       = 1'b0;
    retire       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        // ready in the expiry cycle still completes the fetch
        if (bus.imem_ready) begin
          instr_ld = 1'b1;
          state_n  = S_DECODE;
        end else if (expired) begin
          state_n = S_TRAP;
        end
      end
      S_DECODE: state_n = is_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_load || is_store) begin
          state_n = S_MEMORY;
        end else if (is_branch) begin
          if (branch_taken && (alu_result[1:0] != 2'b00)) begin
            state_n = S_TRAP;
          end else begin
            pc_ld   = 1'b1;
            pc_n    = branch_taken ? alu_result : pc_plus4;
            retire  = 1'b1;
            state_n = S_FETCH;
          end
        end else if (is_jump) begin
          // target is captured here so writeback does not depend on the ALU
          // still presenting it a cycle later
          if (tgt[1]) begin
            state_n = S_TRAP;
          end else begin
            tgt_ld  = 1'b1;
            state_n = S_WB;
          end
        end else if (is_nop) begin
          pc_ld   = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEMORY: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            pc_ld   = 1'b1;
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (expired) begin
          state_n = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_ld   = 1'b1;
        pc_n    = is_jump ? tgt_q : pc_plus4;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_TRAP;
    endcase
    // Requests and strobes are forced low the moment reset is applied,
    // independent of the state register.
    if (!reset_n) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      rf_we        = 1'b0;
    end
  end

endmodule
